// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesting masters and the 256x8 memory.
// The slave modport is the arbiter's view; master is the view of the masters plus the memory.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          Req0;
  logic          We0;
  logic [AW-1:0] Addr0;
  logic [DW-1:0] WData0;
  logic          Ack0;
  logic [DW-1:0] RData0;

  logic          Req1;
  logic          We1;
  logic [AW-1:0] Addr1;
  logic [DW-1:0] WData1;
  logic          Ack1;
  logic [DW-1:0] RData1;

  logic          MemWriteEn;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData;
  logic [DW-1:0] MemRData;
  logic          Busy;

  modport slave (
    input  Req0, We0, Addr0, WData0,
    input  Req1, We1, Addr1, WData1,
    input  MemRData,
    output Ack0, RData0, Ack1, RData1,
    output MemWriteEn, MemAddr, MemWData, Busy
  );

  modport master (
    output Req0, We0, Addr0, WData0,
    output Req1, We1, Addr1, WData1,
    output MemRData,
    input  Ack0, RData0, Ack1, RData1,
    input  MemWriteEn, MemAddr, MemWData, Busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the data memory.
// Every access takes exactly three cycles: latch in IDLE, memory access in SERVE, Ack in DONE.
module dmem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input logic           Clk,
  input logic           Reset_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StServe,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          winner;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    winner   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.Req0 || bus.Req1) begin
          // On a tie the port that did not win last time is granted.
          winner  = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;
          owner_d = winner;
          last_d  = winner;
          we_d    = winner ? bus.We1    : bus.We0;
          addr_d  = winner ? bus.Addr1  : bus.Addr0;
          wdata_d = winner ? bus.WData1 : bus.WData0;
          state_d = StServe;
        end
      end
      StServe: begin
        if (!we_q) begin
          if (owner_q) rdata1_d = bus.MemRData;
          else         rdata0_d = bus.MemRData;
        end
        if (owner_q) ack1_d = 1'b1;
        else         ack0_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // The memory bus is driven only in SERVE so a reset drops the write strobe at once.
  assign bus.MemWriteEn = (state_q == StServe) && we_q;
  assign bus.MemAddr    = (state_q == StServe) ? addr_q  : '0;
  assign bus.MemWData   = (state_q == StServe) ? wdata_q : '0;
  assign bus.Busy       = (state_q != StIdle);

  assign bus.Ack0   = ack0_q;
  assign bus.Ack1   = ack1_q;
  assign bus.RData0 = rdata0_q;
  assign bus.RData1 = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the 256x8 data memory (combinational read, write on posedge Clk when MemWriteEn is high).
- Port 0 is the core load/store unit; port 1 is a secondary master (loader/DMA/debug).
- Each port sees a req/ack handshake with registered read data.
- The arbiter is the only driver of the memory's MemWriteEn, DataAddress and DataIn.

Parameters:
- AW, 8, address width; memory depth is 2**AW.
- DW, 8, data width.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- Req0  in  1  port 0 access request; held until Ack0.
- We0  in  1  port 0 write (1) / read (0); stable while Req0.
- Addr0  in  AW  port 0 address; stable while Req0.
- WData0  in  DW  port 0 write data; stable while Req0.
- Ack0  out  1  one-cycle completion pulse for port 0.
- RData0  out  DW  port 0 read data; valid in Ack0 cycle, held until next port-0 read completes.
- Req1, We1, Addr1, WData1, Ack1, RData1: same as port 0, for port 1.
- MemWriteEn  out  1  to memory write enable.
- MemAddr  out  AW  to memory DataAddress.
- MemWData  out  DW  to memory DataIn.
- MemRData  in  DW  from memory DataOut (combinational read).
- Busy  out  1  high while state is not IDLE.

Behaviour:
- State machine: IDLE -> SERVE -> DONE -> IDLE. One access per 3 cycles, fixed.
- Reset (async, Reset_n=0):
  - state=IDLE, last=1 (port 0 wins the first tie).
  - Ack0=Ack1=0, RData0=RData1=0.
  - Latched addr, wdata, we and owner all cleared to 0.
  - MemWriteEn=0, MemAddr=0, MemWData=0, Busy=0.
- IDLE:
  - No Req: stay in IDLE.
  - Any Req at a rising edge: latch the winner's Addr/WData/We and owner id; go to SERVE.
  - Only one Req: that port wins.
  - Both Req: the port != last wins (round-robin).
  - last updates to the winner when the request is latched.
- SERVE:
  - MemAddr = latched addr, MemWData = latched wdata.
  - MemWriteEn = latched we, decoded combinationally from state. MemWriteEn is 0 in every other state.
  - At the rising edge: if read, RData[owner] <= MemRData (write leaves RData unchanged). Ack[owner] <= 1. Go to DONE.
- DONE:
  - Ack[owner]=1 for exactly this cycle.
  - Requests are ignored in DONE; the requester drops Req in the Ack cycle or issues a new access.
  - Go to IDLE.
  - A Req still high on return to IDLE is a new access.
- Latency: Req rising in cycle N (arbiter in IDLE) -> memory access in N+1 -> Ack and RData in N+2.
- Req changes mid-access:
  - A loser's Req stays pending and wins at the next IDLE.
  - Input changes after latching do not affect the access in flight.
  - Req deasserted before Ack is a protocol error; the access still completes and Ack still pulses.
- Same address from both ports: strict serialization in grant order. A read after a write sees the written value.
- Address wrap: none; Addr passes through unchanged, full 0..2**AW-1 range.
- Reset mid-access:
  - In SERVE, MemWriteEn drops immediately and no write occurs.
  - No Ack is produced.
  - After reset, port 0 has priority on the first tie.
- Busy = (state != IDLE).
- Registered outputs: Ack0/1, RData0/1, state, last and the latched request fields.
- Combinational from the latched request and state: MemWriteEn, MemAddr, MemWData, Busy.

Test Plan:
- Reset then single write: Req0=1, We0=1, Addr0=8'h10, WData0=8'hA5 at cycle 0 -> MemWriteEn=1 with MemAddr=8'h10 in cycle 1; Ack0 pulses in cycle 2; memory[8'h10]=8'hA5.
- Read-back: after the test above, Req1=1, We1=0, Addr1=8'h10 -> RData1=8'hA5 with Ack1 in the third cycle; RData0 unchanged.
- Contention after reset:
  - Req0 and Req1 both high from cycle 0, each re-requesting after Ack.
  - Expect grant order 0,1,0,1.
  - Acks 3 cycles apart (cycles 2,5,8,11).
  - No starvation.
- Same-address ordering:
  - Setup: memory[8'h20]=8'h00; last=0, so port 1 wins the first tie.
  - Port 1 writes 8'h3C and port 0 reads, both at 8'h20 and asserted together.
  - Expected: port 1's write completes first; port 0 then reads 8'h3C.
- Async reset mid-SERVE:
  - Stimulus: Reset_n low between edges during a write to 8'h40 (memory[8'h40]=8'h11 before).
  - Expected: MemWriteEn falls immediately, memory[8'h40] stays 8'h11, Ack0=Ack1=0, Busy=0.
  - After release, the next tie is granted to port 0.
- Held request / RData retention:
  - Stimulus: Req0 held high continuously reading 8'hFF, then 8'h00.
  - Expected: Ack0 every 3 cycles; RData0 updates only in Ack0 cycles and holds its value between them.
